// File: rtl/fetch_aligner.sv
// fetch_aligner
//   Front-end fetch controller for an RV32IC pipeline. Issues word-aligned
//   instruction-memory reads and hands decode one aligned instruction per
//   handshake. An instruction can be compressed (16-bit, zero-extended) or a
//   full 32-bit instruction, including one that straddles a word boundary.
//   Redirects from execute flush the fetch stream and restart it at a new PC.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   redirect_valid flush and restart fetch at redirect_pc
//   redirect_pc    restart PC (bit 0 ignored)
//   imem_read      read request, held until imem_resp
//   imem_address   word-aligned read address, stable while imem_read
//   imem_rdata     read data, valid with imem_resp
//   imem_resp      one-cycle read completion
//   instr_valid    instr/instr_pc/instr_is_c are valid
//   instr_ready    decode accepts when instr_valid & instr_ready
//   instr          32-bit instruction, or {16'h0,halfword} when compressed
//   instr_pc       PC of instr
//   instr_is_c     instr[1:0] != 2'b11
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DRAIN} state_t;

  state_t      fsm, fsm_d;
  // fetch_pc is kept 32 bits wide with bit 0 held at zero.
  // In OUT it is the address of the next undelivered halfword (the buffered
  // one when have_half is set). In FETCH with have_half set it is the word
  // being read, so the buffered halfword sits at fetch_pc-2.
  logic [31:0] fetch_pc, fetch_pc_d;
  logic [15:0] half_buf, half_buf_d;
  logic        have_half, have_half_d;
  // Address of the abandoned read that DRAIN is waiting out.
  logic [31:0] drain_addr, drain_addr_d;
  logic [31:0] instr_d, instr_pc_d;
  logic        instr_is_c_d;

  logic        emit;
  logic [31:0] emit_word, emit_pc;
  logic [15:0] lo, hi;

  assign lo = imem_rdata[15:0];
  assign hi = imem_rdata[31:16];

  // Next-state and output decode for the whole fetch/align machine.
  always_comb begin
    fsm_d        = fsm;
    fetch_pc_d   = fetch_pc;
    half_buf_d   = half_buf;
    have_half_d  = have_half;
    drain_addr_d = drain_addr;
    instr_d      = instr;
    instr_pc_d   = instr_pc;
    instr_is_c_d = instr_is_c;
    emit         = 1'b0;
    emit_word    = 32'h0;
    emit_pc      = 32'h0;

    imem_read    = (fsm == FETCH) || (fsm == DRAIN);
    instr_valid  = (fsm == OUT);
    imem_address = (fsm == DRAIN) ? drain_addr : {fetch_pc[31:2], 2'b00};

    case (fsm)
      IDLE: fsm_d = FETCH;

      FETCH: begin
        if (imem_resp) begin
          if (have_half) begin
            // Upper half of a straddling instruction has arrived.
            emit       = 1'b1;
            emit_word  = {lo, half_buf};
            emit_pc    = fetch_pc - 32'd2;
            half_buf_d = hi;
            fetch_pc_d = fetch_pc + 32'd2;
            fsm_d      = OUT;
          end else if (!fetch_pc[1]) begin
            emit    = 1'b1;
            emit_pc = fetch_pc;
            fsm_d   = OUT;
            if (lo[1:0] != 2'b11) begin
              emit_word   = {16'h0, lo};
              half_buf_d  = hi;
              have_half_d = 1'b1;
              fetch_pc_d  = fetch_pc + 32'd2;
            end else begin
              emit_word  = imem_rdata;
              fetch_pc_d = fetch_pc + 32'd4;
            end
          end else if (hi[1:0] != 2'b11) begin
            emit       = 1'b1;
            emit_word  = {16'h0, hi};
            emit_pc    = fetch_pc;
            fetch_pc_d = fetch_pc + 32'd2;
            fsm_d      = OUT;
          end else begin
            // Odd-halfword start of a full instruction: buffer and read on.
            half_buf_d  = hi;
            have_half_d = 1'b1;
            fetch_pc_d  = fetch_pc + 32'd2;
          end
        end
      end

      OUT: begin
        if (instr_ready) begin
          if (have_half && (half_buf[1:0] != 2'b11)) begin
            // Buffered compressed instruction goes out with no memory access.
            emit        = 1'b1;
            emit_word   = {16'h0, half_buf};
            emit_pc     = fetch_pc;
            fetch_pc_d  = fetch_pc + 32'd2;
            have_half_d = 1'b0;
          end else begin
            fsm_d = FETCH;
            // Buffered half starts a full instruction: fetch the next word.
            if (have_half) fetch_pc_d = fetch_pc + 32'd2;
          end
        end
      end

      DRAIN: begin
        if (imem_resp) fsm_d = FETCH;
      end

      default: fsm_d = IDLE;
    endcase

    // A redirect overrides everything else happening in this cycle.
    if (redirect_valid) begin
      emit        = 1'b0;
      have_half_d = 1'b0;
      fetch_pc_d  = {redirect_pc[31:1], 1'b0};
      if ((fsm == FETCH) && !imem_resp) begin
        fsm_d        = DRAIN;
        drain_addr_d = {fetch_pc[31:2], 2'b00};
      end else if ((fsm == DRAIN) && !imem_resp) begin
        fsm_d = DRAIN;
      end else begin
        fsm_d = FETCH;
      end
    end

    if (emit) begin
      instr_d      = emit_word;
      instr_pc_d   = emit_pc;
      instr_is_c_d = (emit_word[1:0] != 2'b11);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      fetch_pc   <= RESET_PC & 32'hFFFF_FFFE;
      half_buf   <= 16'h0;
      have_half  <= 1'b0;
      drain_addr <= 32'h0;
      instr      <= 32'h0;
      instr_pc   <= 32'h0;
      instr_is_c <= 1'b0;
    end else begin
      fsm        <= fsm_d;
      fetch_pc   <= fetch_pc_d;
      half_buf   <= half_buf_d;
      have_half  <= have_half_d;
      drain_addr <= drain_addr_d;
      instr      <= instr_d;
      instr_pc   <= instr_pc_d;
      instr_is_c <= instr_is_c_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner
//   Self-checking bench for fetch_aligner. A behavioural memory answers reads
//   with random latency. Directed scenarios come first, then a randomized run
//   in which every accepted instruction is compared with a reference model
//   that walks the instruction stream halfword by halfword.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is_c;

  int total = 0;
  int bad   = 0;

  // 4 KB of instruction memory, aliased across the address space.
  logic [31:0] mem [0:1023];
  int          lat_min = 2;
  int          lat_max = 2;
  logic        busy;
  int          cnt;
  logic [31:0] lat_addr;

  fetch_aligner #(.RESET_PC(32'h0000_0060)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_read     (imem_read),
    .imem_address  (imem_address),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_is_c    (instr_is_c)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drives decode/execute inputs for the coming edge, returns on the next falling edge.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] tgt);
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    @(negedge clk);
  endtask

  // Halfword of the program image at byte address a.
  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Waits for an instruction, checks it, optionally stalls decode, then accepts it.
  task automatic expectInstr(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                             input logic e_c, input int hold);
    int n;
    n = 0;
    while (!instr_valid && n < 50) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      n++;
    end
    if (!instr_valid) begin
      checkOutput({tag, "_timeout"}, 32'h0, 32'h1);
      return;
    end
    checkOutput({tag, "_instr"}, instr, e_instr);
    checkOutput({tag, "_pc"}, instr_pc, e_pc);
    checkOutput({tag, "_is_c"}, 32'(instr_is_c), 32'(e_c));
    for (int i = 0; i < hold; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput({tag, "_hold_valid"}, 32'(instr_valid), 32'h1);
      checkOutput({tag, "_hold_instr"}, instr, e_instr);
      checkOutput({tag, "_hold_pc"}, instr_pc, e_pc);
      checkOutput({tag, "_hold_read"}, 32'(imem_read), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
  endtask

  // Memory responder: one read at a time, random latency, address must stay put.
  initial begin
    imem_resp  = 1'b0;
    imem_rdata = 32'h0;
    busy       = 1'b0;
    cnt        = 0;
    lat_addr   = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_resp = 1'b0;
        busy      = 1'b0;
      end else if (imem_resp) begin
        imem_resp = 1'b0;
        busy      = 1'b0;
      end else if (imem_read) begin
        if (!busy) begin
          busy     = 1'b1;
          cnt      = int'($urandom_range(lat_max, lat_min));
          lat_addr = imem_address;
          checkOutput("addr_align", 32'(imem_address[1:0]), 32'h0);
        end else begin
          checkOutput("addr_stable", imem_address, lat_addr);
        end
        if (cnt == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = mem[imem_address[11:2]];
        end else begin
          cnt--;
        end
      end
    end
  end

  // Directed scenarios followed by the randomized run.
  initial begin
    logic [31:0] model_pc, exp_instr, tgt, held_instr, held_pc;
    logic [15:0] h0, hh;
    logic        rdy, redir, held;
    int          len, idle, n;

    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      for (int k = 0; k < 2; k++) begin
        hh = 16'($urandom);
        if ($urandom_range(2, 0) == 0) hh[1:0] = 2'b11;
        else hh[1:0] = 2'($urandom_range(2, 0));
        if (k == 0) w[15:0] = hh;
        else w[31:16] = hh;
      end
      mem[i] = w;
    end
    mem[24] = 32'h0000_0513;
    mem[25] = 32'h4501_4581;
    mem[26] = 32'h0513_4501;
    mem[27] = 32'hABCD_0000;
    mem[64] = 32'h0001_4501;

    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_read", 32'(imem_read), 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_pc", instr_pc, 32'h0);
    checkOutput("rst_is_c", 32'(instr_is_c), 32'h0);
    rst_n = 1'b1;

    expectInstr("t1", 32'h0000_0513, 32'h60, 1'b0, 0);
    checkOutput("t1_next_read", 32'(imem_read), 32'h1);
    checkOutput("t1_next_addr", imem_address, 32'h64);

    expectInstr("t2a", 32'h0000_4581, 32'h64, 1'b1, 0);
    checkOutput("t2_b2b_valid", 32'(instr_valid), 32'h1);
    checkOutput("t2_b2b_noread", 32'(imem_read), 32'h0);
    expectInstr("t2b", 32'h0000_4501, 32'h66, 1'b1, 0);

    expectInstr("t3a", 32'h0000_4501, 32'h68, 1'b1, 0);
    expectInstr("t3b", 32'h0000_0513, 32'h6A, 1'b0, 0);
    expectInstr("t3c", 32'h0000_ABCD, 32'h6E, 1'b1, 0);
    checkOutput("t3_next_read", 32'(imem_read), 32'h1);
    checkOutput("t3_next_addr", imem_address, 32'h70);

    applyStimulus(1'b0, 1'b1, 32'h102);
    checkOutput("t4_drain_read", 32'(imem_read), 32'h1);
    checkOutput("t4_drain_addr", imem_address, 32'h70);
    checkOutput("t4_drain_valid", 32'(instr_valid), 32'h0);
    expectInstr("t4", 32'h0000_0001, 32'h102, 1'b1, 3);

    checkOutput("t6_pre_read", 32'(imem_read), 32'h1);
    instr_ready = 1'b0;
    rst_n       = 1'b0;
    #1;
    checkOutput("t6_valid", 32'(instr_valid), 32'h0);
    checkOutput("t6_read", 32'(imem_read), 32'h0);
    checkOutput("t6_instr", instr, 32'h0);
    checkOutput("t6_pc", instr_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!imem_read && n < 10) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      n++;
    end
    checkOutput("t6_first_read", 32'(imem_read), 32'h1);
    checkOutput("t6_first_addr", imem_address, 32'h60);

    // Randomized run against the stream model.
    lat_min  = 0;
    lat_max  = 3;
    model_pc = 32'h60;
    idle     = 0;
    held     = 1'b0;
    held_instr = 32'h0;
    held_pc    = 32'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (held) begin
        checkOutput("hold_valid", 32'(instr_valid), 32'h1);
        checkOutput("hold_instr", instr, held_instr);
        checkOutput("hold_pc", instr_pc, held_pc);
      end
      redir = ($urandom_range(99, 0) < 3);
      rdy   = ($urandom_range(99, 0) < 70);
      tgt   = 32'($urandom_range(4095, 0));
      held  = 1'b0;
      if (redir) begin
        model_pc = tgt & 32'hFFFF_FFFE;
        idle     = 0;
      end else if (instr_valid && rdy) begin
        h0 = hw(model_pc);
        if (h0[1:0] != 2'b11) begin
          exp_instr = {16'h0, h0};
          len       = 2;
        end else begin
          exp_instr = {hw(model_pc + 32'd2), h0};
          len       = 4;
        end
        checkOutput("rnd_instr", instr, exp_instr);
        checkOutput("rnd_pc", instr_pc, model_pc);
        checkOutput("rnd_is_c", 32'(instr_is_c), (len == 2) ? 32'h1 : 32'h0);
        model_pc = model_pc + 32'(len);
        idle     = 0;
      end else if (instr_valid) begin
        held       = 1'b1;
        held_instr = instr;
        held_pc    = instr_pc;
      end
      applyStimulus(rdy, redir, tgt);
      idle++;
      if (idle > 200) begin
        checkOutput("rnd_watchdog", 32'(idle), 32'h0);
        break;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
